game_frame_sequencer: RTL and testbench
=======================================

// Module: game_frame_sequencer
// PURPOSE
//   Frame-level scheduler for the Pong game logic. Watches the hpos/vpos
//   counters of the 640x480@60Hz sync generator and, once per frame at the
//   start of vertical blanking, sequences four game-update phases
//   (0 input, 1 paddles, 2 ball/collision, 3 score).
//   Each phase uses a req/ack handshake. Game state therefore changes only
//   while nothing is drawn. Watchdog and overrun flags catch misbehaving phases.
// PARAMETERS
//   V_ACTIVE        480   first vblank line (vpos value that opens blanking)
//   TIMEOUT_CYCLES  4096  max cycles a phase req may stay high without ack
//   FRAME_DIV       1     run the sequence on every FRAME_DIV-th vblank (>=1)
//   FRAME_CNT_W     16    width of frame_count
// PORTS
//   clk          in   1            pixel clock (25 MHz)
//   reset_n      in   1            synchronous, active-low reset
//   hpos         in   10           horizontal position from sync generator
//   vpos         in   10           vertical position from sync generator
//   pause        in   1            1 = ignore vblank starts (no new sequence)
//   phase_ack    in   4            per-phase completion, bit p acks phase p
//   clear_err    in   1            clears sticky error flags
//   phase_req    out  4            one-hot request, held until acked/aborted
//   busy         out  1            sequence in progress
//   frame_tick   out  1            1-cycle pulse: all 4 phases completed
//   frame_count  out  FRAME_CNT_W  completed sequences, wraps modulo 2^W
//   overrun      out  1            sticky: sequence still busy at active start
//   timeout_err  out  1            sticky: phase exceeded TIMEOUT_CYCLES
// BEHAVIOUR
// - One clock, synchronous active-low reset. All outputs registered; all 0 on
//   reset, as are div_cnt, watchdog and state. Reset mid-phase: outputs 0 next edge.
// - vblank_start = (hpos==0 && vpos==V_ACTIVE).
//   active_start = (hpos==0 && vpos==0). Each is true exactly 1 cycle per frame.
// - States: IDLE, PHASE(p), p = 0..3. busy = (state != IDLE).
// - IDLE:
//   - On vblank_start with pause=1: nothing happens; div_cnt is held.
//   - On vblank_start with pause=0 and div_cnt==FRAME_DIV-1: div_cnt<=0,
//     go to PHASE(0). Otherwise div_cnt increments.
// - Latency: vblank_start at cycle t gives phase_req=4'b0001 and busy=1 at t+1.
// - PHASE(p): phase_req=(1<<p).
//   - Ack accepted when phase_ack[p]=1 while phase_req[p]=1, including the first
//     req cycle. Other ack bits are ignored.
//   - Ack at t, p<3: phase_req=(1<<(p+1)) at t+1. Back-to-back, no gap.
//   - Ack at t, p=3: phase_req=0, frame_tick=1 for one cycle at t+1,
//     frame_count+1 (wraps), state IDLE.
// - Watchdog: restarts at 0 on entry to each phase and counts cycles req is high.
//   - If req stays high TIMEOUT_CYCLES cycles with no ack: timeout_err<=1,
//     phase_req<=0, IDLE, no frame_tick.
//   - Abort edge is req rise + TIMEOUT_CYCLES.
// - active_start while busy: overrun<=1, phase_req<=0, IDLE next cycle,
//   no frame_tick, count unchanged.
// - Same-cycle priority: reset > overrun abort > ack > timeout.
// - clear_err zeroes overrun/timeout_err. If a set event occurs in the same
//   cycle, set wins.
// - vblank_start while busy cannot occur (active_start aborts first). If forced,
//   it is ignored.
// - Errors never block future frames: the next vblank starts a new sequence.
// TESTING
// 1. Reset, then phase_ack=phase_req (loopback), vblank_start at t:
//    req 0001@t+1, 0010@t+2, 0100@t+3, 1000@t+4; frame_tick@t+5;
//    frame_count=1; busy 0@t+5.
// 2. TIMEOUT_CYCLES=16, ack1 never asserted, req1 rises at r:
//    timeout_err=1 and phase_req=0 at r+16, frame_count unchanged.
// 3. Phase 2 held unacked until vpos/hpos wrap to 0:
//    overrun=1, busy=0 next cycle. Next vblank runs a clean sequence.
// 4. pause=1 across 3 vblanks: no req. Then FRAME_DIV=2 with pause=0:
//    sequences start on 2nd and 4th vblank only.
// 5. reset_n=0 while req=0100: all outputs 0 next edge. clear_err in the same
//    cycle as a timeout: timeout_err stays 1.
// 6. FRAME_CNT_W=4, 16 completed sequences: frame_count 15 -> 0, frame_tick
//    each time.

Source files
------------

// File: rtl/game_frame_sequencer_if.sv
// Phase request/acknowledge bundle between the frame sequencer and the
// game-update engines. Bit p of each vector belongs to update phase p.
interface game_frame_sequencer_if;
  logic [3:0] phase_req;
  logic [3:0] phase_ack;

  modport master (output phase_req, input phase_ack);
  modport slave  (input phase_req, output phase_ack);
endinterface

// File: rtl/game_frame_sequencer.sv
// Frame-level scheduler for the Pong game logic. At the start of vertical
// blanking it walks the four game-update phases (input, paddles,
// ball/collision, score) through a one-hot req/ack handshake, so game state
// only changes while nothing is drawn. A per-phase watchdog and an
// overrun detector (still busy when the next active frame begins) abort a
// stuck sequence and leave sticky error flags behind.
module game_frame_sequencer #(
  parameter int V_ACTIVE       = 480,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int FRAME_DIV      = 1,
  parameter int FRAME_CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [9:0]                 hpos,
  input  logic [9:0]                 vpos,
  input  logic                       pause,
  input  logic                       clear_err,
  game_frame_sequencer_if.master     bus,
  output logic                       busy,
  output logic                       frame_tick,
  output logic [FRAME_CNT_W-1:0]     frame_count,
  output logic                       overrun,
  output logic                       timeout_err
);

  // Divider and watchdog widths; a divide-by-one still keeps a 1-bit counter.
  localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [9:0]       V_ACTIVE_L = 10'(V_ACTIVE);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(FRAME_DIV - 1);
  // Watchdog value seen in the last cycle a request may stay high unacked.
  localparam logic [WD_W-1:0]  WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PH0  = 3'd1,
    S_PH1  = 3'd2,
    S_PH2  = 3'd3,
    S_PH3  = 3'd4
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [DIV_W-1:0]       div_cnt;
  logic [DIV_W-1:0]       div_nxt;
  logic [WD_W-1:0]        wd_cnt;
  logic [WD_W-1:0]        wd_nxt;
  logic [FRAME_CNT_W-1:0] count_nxt;
  logic                   tick_nxt;
  logic                   overrun_nxt;
  logic                   timeout_nxt;
  logic [3:0]             req_nxt;
  logic                   vblank_start;
  logic                   active_start;
  logic                   ack_hit;

  // One-hot request pattern driven while the sequencer sits in a given state.
  function automatic logic [3:0] req_of_state(input state_t s);
    logic [3:0] r;
    case (s)
      S_PH0:   r = 4'b0001;
      S_PH1:   r = 4'b0010;
      S_PH2:   r = 4'b0100;
      S_PH3:   r = 4'b1000;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  // Phase that follows an acknowledged phase (the last one is handled apart).
  function automatic state_t phase_after(input state_t s);
    state_t n;
    case (s)
      S_PH0:   n = S_PH1;
      S_PH1:   n = S_PH2;
      S_PH2:   n = S_PH3;
      default: n = S_IDLE;
    endcase
    return n;
  endfunction

  assign vblank_start = (hpos == 10'd0) && (vpos == V_ACTIVE_L);
  assign active_start = (hpos == 10'd0) && (vpos == 10'd0);
  // Only the ack bit of the phase currently requested counts.
  assign ack_hit      = |(bus.phase_ack & bus.phase_req);

  // Next-state and next-output decode; priority is overrun > ack > timeout.
  always_comb begin
    state_nxt   = state;
    div_nxt     = div_cnt;
    wd_nxt      = wd_cnt;
    count_nxt   = frame_count;
    tick_nxt    = 1'b0;
    overrun_nxt = overrun;
    timeout_nxt = timeout_err;

    if (clear_err) begin
      overrun_nxt = 1'b0;
      timeout_nxt = 1'b0;
    end else begin
      overrun_nxt = overrun;
      timeout_nxt = timeout_err;
    end

    case (state)
      S_IDLE: begin
        wd_nxt = {WD_W{1'b0}};
        if (vblank_start && !pause) begin
          if (div_cnt == DIV_LAST) begin
            div_nxt   = {DIV_W{1'b0}};
            state_nxt = S_PH0;
          end else begin
            div_nxt = div_cnt + DIV_W'(1);
          end
        end else begin
          div_nxt = div_cnt;
        end
      end
      S_PH0, S_PH1, S_PH2, S_PH3: begin
        if (active_start) begin
          overrun_nxt = 1'b1;
          state_nxt   = S_IDLE;
          wd_nxt      = {WD_W{1'b0}};
        end else if (ack_hit) begin
          wd_nxt = {WD_W{1'b0}};
          if (state == S_PH3) begin
            state_nxt = S_IDLE;
            tick_nxt  = 1'b1;
            count_nxt = frame_count + FRAME_CNT_W'(1);
          end else begin
            state_nxt = phase_after(state);
          end
        end else if (wd_cnt == WD_LAST) begin
          timeout_nxt = 1'b1;
          state_nxt   = S_IDLE;
          wd_nxt      = {WD_W{1'b0}};
        end else begin
          wd_nxt = wd_cnt + WD_W'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        wd_nxt    = {WD_W{1'b0}};
      end
    endcase

    req_nxt = req_of_state(state_nxt);
  end

  // State, counters and all outputs are registered; reset clears everything.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      div_cnt       <= {DIV_W{1'b0}};
      wd_cnt        <= {WD_W{1'b0}};
      bus.phase_req <= 4'b0000;
      busy          <= 1'b0;
      frame_tick    <= 1'b0;
      frame_count   <= {FRAME_CNT_W{1'b0}};
      overrun       <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      state         <= state_nxt;
      div_cnt       <= div_nxt;
      wd_cnt        <= wd_nxt;
      bus.phase_req <= req_nxt;
      busy          <= (state_nxt != S_IDLE);
      frame_tick    <= tick_nxt;
      frame_count   <= count_nxt;
      overrun       <= overrun_nxt;
      timeout_err   <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_game_frame_sequencer.sv
// Directed bench for game_frame_sequencer. dut runs every vblank with a short
// watchdog and a 4-bit frame counter; dut2 divides frames by two and always
// loops its acks back.
module tb_game_frame_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] hpos = 10'd5;
  logic [9:0] vpos = 10'd100;
  logic       pause = 1'b0;
  logic       clear_err = 1'b0;
  logic       loop = 1'b1;
  logic [3:0] ack_mask = 4'b1111;
  logic [3:0] manual_ack = 4'b0000;

  logic       busy, frame_tick, overrun, timeout_err;
  logic [3:0] frame_count;
  logic       busy2, frame_tick2, overrun2, timeout_err2;
  logic [3:0] frame_count2;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_count = 4'd0;

  game_frame_sequencer_if bus1 ();
  game_frame_sequencer_if bus2 ();

  assign bus1.phase_ack = loop ? (bus1.phase_req & ack_mask) : manual_ack;
  assign bus2.phase_ack = bus2.phase_req;

  game_frame_sequencer #(.V_ACTIVE(480), .TIMEOUT_CYCLES(16), .FRAME_DIV(1), .FRAME_CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .hpos(hpos), .vpos(vpos), .pause(pause),
    .clear_err(clear_err), .bus(bus1), .busy(busy), .frame_tick(frame_tick),
    .frame_count(frame_count), .overrun(overrun), .timeout_err(timeout_err)
  );

  game_frame_sequencer #(.V_ACTIVE(480), .TIMEOUT_CYCLES(16), .FRAME_DIV(2), .FRAME_CNT_W(4)) dut2 (
    .clk(clk), .reset_n(reset_n), .hpos(hpos), .vpos(vpos), .pause(pause),
    .clear_err(clear_err), .bus(bus2), .busy(busy2), .frame_tick(frame_tick2),
    .frame_count(frame_count2), .overrun(overrun2), .timeout_err(timeout_err2)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle vblank_start; outputs after return reflect the following edge.
  task automatic vblank();
    hpos = 10'd0;
    vpos = 10'd480;
    step();
    hpos = 10'd5;
    vpos = 10'd100;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    checks++;
    if ({bus1.phase_req, busy, frame_tick, frame_count, overrun, timeout_err} !== 12'd0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b busy=%b tick=%b cnt=%0d ovr=%b to=%b, want all 0",
               bus1.phase_req, busy, frame_tick, frame_count, overrun, timeout_err);
    end
    reset_n = 1'b1;
    exp_count = 4'd0;
    step();
  endtask

  task automatic test_sequence();
    loop = 1'b1;
    ack_mask = 4'b1111;
    vblank();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus1.phase_req !== (4'b0001 << i) || busy !== 1'b1) begin
        errors++;
        $display("FAIL seq_req%0d: got req=%b busy=%b, want req=%b busy=1",
                 i, bus1.phase_req, busy, 4'b0001 << i);
      end
      step();
    end
    exp_count = exp_count + 4'd1;
    checks++;
    if (frame_tick !== 1'b1 || bus1.phase_req !== 4'b0000 || busy !== 1'b0 || frame_count !== exp_count) begin
      errors++;
      $display("FAIL seq_done: got tick=%b req=%b busy=%b cnt=%0d, want tick=1 req=0000 busy=0 cnt=%0d",
               frame_tick, bus1.phase_req, busy, frame_count, exp_count);
    end
    step();
    checks++;
    if (frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL seq_tick_pulse: got tick=%b, want 0", frame_tick);
    end
  endtask

  // Drives phase 0 ack, then starves phase 1 until the watchdog fires.
  task automatic test_timeout(input logic clear_at_abort);
    loop = 1'b0;
    manual_ack = 4'b0001;
    vblank();
    step();
    manual_ack = 4'b1101;
    checks++;
    if (bus1.phase_req !== 4'b0010) begin
      errors++;
      $display("FAIL to_req1_rise: got req=%b, want 0010", bus1.phase_req);
    end
    for (int k = 1; k < 16; k++) step();
    checks++;
    if (bus1.phase_req !== 4'b0010 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL to_early: at r+15 got req=%b to=%b, want req=0010 to=0", bus1.phase_req, timeout_err);
    end
    clear_err = clear_at_abort;
    step();
    clear_err = 1'b0;
    checks++;
    if (timeout_err !== 1'b1 || bus1.phase_req !== 4'b0000 || busy !== 1'b0 ||
        frame_tick !== 1'b0 || frame_count !== exp_count) begin
      errors++;
      $display("FAIL to_abort(clr=%b): got to=%b req=%b busy=%b tick=%b cnt=%0d, want to=1 req=0000 busy=0 tick=0 cnt=%0d",
               clear_at_abort, timeout_err, bus1.phase_req, busy, frame_tick, frame_count, exp_count);
    end
    manual_ack = 4'b0000;
    loop = 1'b1;
  endtask

  task automatic test_clear();
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    checks++;
    if (timeout_err !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL clear_err: got to=%b ovr=%b, want 0 0", timeout_err, overrun);
    end
  endtask

  task automatic test_overrun();
    loop = 1'b1;
    ack_mask = 4'b1011;
    vblank();
    step();
    step();
    for (int k = 0; k < 5; k++) step();
    checks++;
    if (bus1.phase_req !== 4'b0100 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_hold: got req=%b ovr=%b, want req=0100 ovr=0", bus1.phase_req, overrun);
    end
    hpos = 10'd0;
    vpos = 10'd0;
    step();
    hpos = 10'd5;
    vpos = 10'd100;
    checks++;
    if (overrun !== 1'b1 || busy !== 1'b0 || bus1.phase_req !== 4'b0000 ||
        frame_tick !== 1'b0 || frame_count !== exp_count) begin
      errors++;
      $display("FAIL ovr_abort: got ovr=%b busy=%b req=%b tick=%b cnt=%0d, want ovr=1 busy=0 req=0000 tick=0 cnt=%0d",
               overrun, busy, bus1.phase_req, frame_tick, frame_count, exp_count);
    end
    ack_mask = 4'b1111;
    step();
    test_sequence();
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_sticky: got ovr=%b, want 1", overrun);
    end
  endtask

  task automatic test_pause_div();
    test_reset();
    pause = 1'b1;
    for (int v = 0; v < 3; v++) begin
      vblank();
      checks++;
      if (bus1.phase_req !== 4'b0000 || busy !== 1'b0 || bus2.phase_req !== 4'b0000) begin
        errors++;
        $display("FAIL pause_vb%0d: got req=%b busy=%b req2=%b, want 0000 0 0000",
                 v, bus1.phase_req, busy, bus2.phase_req);
      end
      step();
      step();
    end
    pause = 1'b0;
    for (int v = 1; v <= 4; v++) begin
      vblank();
      checks++;
      if (bus2.phase_req !== ((v % 2 == 0) ? 4'b0001 : 4'b0000)) begin
        errors++;
        $display("FAIL div2_vb%0d: got req2=%b, want %b",
                 v, bus2.phase_req, (v % 2 == 0) ? 4'b0001 : 4'b0000);
      end
      for (int k = 0; k < 6; k++) step();
    end
    checks++;
    if (frame_count2 !== 4'd2 || frame_count !== 4'd4) begin
      errors++;
      $display("FAIL div_counts: got cnt2=%0d cnt=%0d, want 2 4", frame_count2, frame_count);
    end
    exp_count = 4'd4;
  endtask

  task automatic test_reset_mid();
    loop = 1'b1;
    ack_mask = 4'b1011;
    vblank();
    step();
    step();
    checks++;
    if (bus1.phase_req !== 4'b0100) begin
      errors++;
      $display("FAIL rst_mid_pre: got req=%b, want 0100", bus1.phase_req);
    end
    reset_n = 1'b0;
    step();
    checks++;
    if ({bus1.phase_req, busy, frame_tick, frame_count, overrun, timeout_err} !== 12'd0) begin
      errors++;
      $display("FAIL rst_mid: got req=%b busy=%b tick=%b cnt=%0d ovr=%b to=%b, want all 0",
               bus1.phase_req, busy, frame_tick, frame_count, overrun, timeout_err);
    end
    reset_n = 1'b1;
    ack_mask = 4'b1111;
    exp_count = 4'd0;
    step();
  endtask

  task automatic test_wrap();
    loop = 1'b1;
    ack_mask = 4'b1111;
    for (int s = 0; s < 16; s++) begin
      vblank();
      for (int k = 0; k < 4; k++) step();
      exp_count = exp_count + 4'd1;
      checks++;
      if (frame_tick !== 1'b1 || frame_count !== exp_count) begin
        errors++;
        $display("FAIL wrap_seq%0d: got tick=%b cnt=%0d, want tick=1 cnt=%0d",
                 s, frame_tick, frame_count, exp_count);
      end
      step();
    end
    checks++;
    if (frame_count !== 4'd0) begin
      errors++;
      $display("FAIL wrap_zero: got cnt=%0d, want 0", frame_count);
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_timeout(1'b0);
    test_clear();
    test_timeout(1'b1);
    test_clear();
    test_overrun();
    test_pause_div();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
